// File: rtl/prog_rom_loader.sv
// prog_rom_loader: writable program memory for the 8-bit CPU fetch stage.
// Serves registered fetches with one cycle of latency. A host streams a new
// program in over a valid/ready port and gets a running checksum back.
// Fetch is stalled while a load is in progress.
module prog_rom_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    output logic              busy,
    output logic [DATA_W-1:0] checksum
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    // Program storage; deliberately outside the reset domain.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] cks_q, cks_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic              fvalid_q, fvalid_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic              start_ok;
    logic              xfer;
    logic              last;

    // Only the low IDX_W bits of the write pointer address the memory.
    logic unused_ptr_bits;
    assign unused_ptr_bits = ^wr_ptr_q;

    // Next-state logic for fetch, load handshake and checksum.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        cks_d    = cks_q;
        fdata_d  = fdata_q;
        fvalid_d = 1'b0;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        start_ok = (load_len != '0) && (load_len <= DEPTH_L);
        xfer     = (state_q == ST_LOAD) && load_valid && ready_q;
        last     = xfer && ({1'b0, wr_ptr_q} == (len_q - LEN_ONE));

        case (state_q)
            ST_RUN: begin
                if (load_start && start_ok) begin
                    // Accepted start wins over a fetch issued in the same cycle.
                    state_d  = ST_LOAD;
                    len_d    = load_len;
                    wr_ptr_d = '0;
                    cks_d    = '0;
                    ready_d  = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    err_d = load_start;
                    if (fetch_en) begin
                        fvalid_d = 1'b1;
                        if ({1'b0, fetch_addr} < DEPTH_L) begin
                            fdata_d = mem_q[fetch_addr[IDX_W-1:0]];
                        end else begin
                            fdata_d = '0;
                        end
                    end
                end
            end
            default: begin
                if (xfer) begin
                    wr_en    = rst_n;
                    cks_d    = cks_q + load_data;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (last) begin
                        state_d = ST_RUN;
                        ready_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            len_q    <= '0;
            wr_ptr_q <= '0;
            cks_q    <= '0;
            fdata_q  <= '0;
            fvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            cks_q    <= cks_d;
            fdata_q  <= fdata_d;
            fvalid_q <= fvalid_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Memory write port; words land before the state returns to RUN.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= load_data;
        end
    end

    assign fetch_data  = fdata_q;
    assign fetch_valid = fvalid_q;
    assign load_ready  = ready_q;
    assign load_done   = done_q;
    assign load_err    = err_q;
    assign busy        = busy_q;
    assign checksum    = cks_q;

endmodule

// File: tb/tb_prog_rom_loader.sv
// Self-checking bench for prog_rom_loader: a DEPTH=256 instance for the main
// scenarios and a DEPTH=128 instance for rejection and out-of-range fetches.
module tb_prog_rom_loader;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_en = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic [DW-1:0] load_data = '0;
    logic          load_valid = 1'b0;
    logic          fetch_en_b = 1'b0;
    logic          load_start_b = 1'b0;

    logic [DW-1:0] fetch_data, fetch_data_b;
    logic          fetch_valid, fetch_valid_b;
    logic          load_ready, load_ready_b;
    logic          load_done, load_done_b;
    logic          load_err, load_err_b;
    logic          busy, busy_b;
    logic [DW-1:0] checksum, checksum_b;

    int checks = 0;
    int errors = 0;

    // Reference state: memory image and checksum of the last load.
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] model_cks;
    logic [DW-1:0] words [256];
    logic [DW-1:0] prog [11];

    // Observations gathered by run_load.
    int ld_ready_cyc, ld_done_early, ld_err_seen, ld_fv_seen, ld_busy_bad;
    bit ld_timeout;

    prog_rom_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .load_start(load_start), .load_len(load_len),
        .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .load_done(load_done), .load_err(load_err),
        .busy(busy), .checksum(checksum)
    );

    prog_rom_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(128)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .fetch_en(fetch_en_b), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data_b), .fetch_valid(fetch_valid_b),
        .load_start(load_start_b), .load_len(load_len),
        .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready_b), .load_done(load_done_b), .load_err(load_err_b),
        .busy(busy_b), .checksum(checksum_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a load of words[0..len-1] into dut_a and updates the model.
    // mode 0: valid held high, 1: valid pattern 1,0,0, 2: random valid plus
    // random load_start noise (must be ignored while loading).
    task automatic run_load(input int len, input int mode, input bit hold_fetch);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        ld_ready_cyc = 0; ld_done_early = 0; ld_err_seen = 0;
        ld_fv_seen = 0; ld_busy_bad = 0;
        load_start = 1'b1;
        load_len   = len[AW:0];
        fetch_en   = hold_fetch;
        fetch_addr = '0;
        tick();
        load_start = 1'b0;
        model_cks  = '0;
        while (idx < len && cyc < 4000) begin
            case (mode)
                0:       load_valid = 1'b1;
                1:       load_valid = (cyc % 3 == 0);
                default: load_valid = 1'($urandom_range(0, 1));
            endcase
            load_data = words[idx];
            if (mode == 2) begin
                load_start = 1'($urandom_range(0, 1));
                load_len   = 9'($urandom);
            end
            if (load_ready)  ld_ready_cyc++;
            if (!busy)       ld_busy_bad++;
            if (load_done)   ld_done_early++;
            if (load_err)    ld_err_seen++;
            if (fetch_valid) ld_fv_seen++;
            if (load_valid && load_ready) begin
                model_mem[idx] = words[idx];
                model_cks      = model_cks + words[idx];
                idx++;
            end
            tick();
            cyc++;
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        ld_timeout = (idx < len);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({fetch_data, fetch_valid, load_ready, load_done, load_err, busy, checksum} !== '0) begin
            errors++;
            $display("FAIL reset_a: got data=%0h fv=%0b rdy=%0b done=%0b err=%0b busy=%0b cks=%0h required all 0",
                     fetch_data, fetch_valid, load_ready, load_done, load_err, busy, checksum);
        end
        checks++;
        if ({fetch_data_b, fetch_valid_b, load_ready_b, load_done_b, load_err_b, busy_b, checksum_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs not all zero in reset");
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_sequence();
        for (int i = 0; i < 11; i++) words[i] = prog[i];
        run_load(11, 0, 1'b0);
        checks++;
        if (ld_timeout || ld_ready_cyc != 11) begin
            errors++;
            $display("FAIL load_ready_cycles: got %0d timeout=%0b required 11", ld_ready_cyc, ld_timeout);
        end
        checks++;
        if (ld_busy_bad != 0 || ld_done_early != 0) begin
            errors++;
            $display("FAIL load_busy_during: busy_low=%0d early_done=%0d required 0 0", ld_busy_bad, ld_done_early);
        end
        checks++;
        if (load_done !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done_pulse: done=%0b busy=%0b rdy=%0b required 1 0 0", load_done, busy, load_ready);
        end
        checks++;
        if (checksum !== 8'h86) begin
            errors++;
            $display("FAIL load_checksum: got %0h required 86", checksum);
        end
        tick();
        checks++;
        if (load_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done_width: done=%0b busy=%0b required 0 0", load_done, busy);
        end
    endtask

    task automatic test_fetch_after_load();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] exp   [3];
        addrs[0] = 8'h04; addrs[1] = 8'h0A; addrs[2] = 8'h0B;
        exp[0]   = 8'h44; exp[1]   = 8'hC1; exp[2]   = 8'h00;
        fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = addrs[i];
            tick();
            checks++;
            if (fetch_valid !== 1'b1 || fetch_data !== exp[i]) begin
                errors++;
                $display("FAIL fetch_seq[%0d]: got fv=%0b data=%0h required 1 %0h", i, fetch_valid, fetch_data, exp[i]);
            end
        end
        fetch_en   = 1'b0;
        fetch_addr = 8'h04;
        tick();
        checks++;
        if (fetch_valid !== 1'b0 || fetch_data !== 8'h00) begin
            errors++;
            $display("FAIL fetch_hold: got fv=%0b data=%0h required 0 00", fetch_valid, fetch_data);
        end
    endtask

    task automatic test_reject();
        logic [AW:0] bad [2];
        bad[0] = 9'd0; bad[1] = 9'd257;
        for (int i = 0; i < 2; i++) begin
            load_start = 1'b1;
            load_len   = bad[i];
            tick();
            load_start = 1'b0;
            checks++;
            if (load_err !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b0 || checksum !== 8'h86) begin
                errors++;
                $display("FAIL reject_a[%0d]: err=%0b busy=%0b rdy=%0b cks=%0h required 1 0 0 86",
                         i, load_err, busy, load_ready, checksum);
            end
            tick();
            checks++;
            if (load_err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reject_a_pulse[%0d]: err=%0b busy=%0b required 0 0", i, load_err, busy);
            end
        end
        load_start_b = 1'b1;
        load_len     = 9'd129;
        tick();
        load_start_b = 1'b0;
        checks++;
        if (load_err_b !== 1'b1 || busy_b !== 1'b0 || checksum_b !== 8'h00) begin
            errors++;
            $display("FAIL reject_b_129: err=%0b busy=%0b cks=%0h required 1 0 00", load_err_b, busy_b, checksum_b);
        end
        tick();
        checks++;
        if (load_err_b !== 1'b0) begin
            errors++;
            $display("FAIL reject_b_pulse: err=%0b required 0", load_err_b);
        end
    endtask

    task automatic test_out_of_range();
        int idx;
        int cyc;
        // Put a nonzero word at 72 (= 200 mod 128) so an alias would show.
        idx = 0;
        cyc = 0;
        load_start_b = 1'b1;
        load_len     = 9'd73;
        tick();
        load_start_b = 1'b0;
        while (idx < 73 && cyc < 500) begin
            load_valid = 1'b1;
            load_data  = 8'(idx + 1);
            if (load_ready_b) idx++;
            tick();
            cyc++;
        end
        load_valid = 1'b0;
        tick();
        fetch_en_b = 1'b1;
        fetch_addr = 8'd200;
        tick();
        checks++;
        if (fetch_valid_b !== 1'b1 || fetch_data_b !== 8'h00) begin
            errors++;
            $display("FAIL oor_fetch_200: got fv=%0b data=%0h required 1 00", fetch_valid_b, fetch_data_b);
        end
        fetch_addr = 8'd72;
        tick();
        fetch_en_b = 1'b0;
        checks++;
        if (fetch_valid_b !== 1'b1 || fetch_data_b !== 8'd73) begin
            errors++;
            $display("FAIL oor_fetch_72: got fv=%0b data=%0h required 1 49", fetch_valid_b, fetch_data_b);
        end
        tick();
    endtask

    // Random loads with random valid gaps, then random fetch traffic.
    task automatic test_random(input int iters);
        logic          exp_v;
        logic [DW-1:0] exp_d;
        int            len;
        for (int it = 0; it < iters; it++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) words[i] = 8'($urandom);
            run_load(len, 2, 1'b0);
            checks++;
            if (ld_timeout || ld_err_seen != 0 || ld_done_early != 0) begin
                errors++;
                $display("FAIL rand_load[%0d]: timeout=%0b err=%0d early_done=%0d required 0 0 0",
                         it, ld_timeout, ld_err_seen, ld_done_early);
            end
            checks++;
            if (load_done !== 1'b1 || checksum !== model_cks) begin
                errors++;
                $display("FAIL rand_done_cks[%0d]: done=%0b cks=%0h required 1 %0h", it, load_done, checksum, model_cks);
            end
            exp_d = fetch_data;
            for (int k = 0; k < 12; k++) begin
                fetch_en   = 1'($urandom_range(0, 1));
                fetch_addr = 8'($urandom_range(0, 63));
                exp_v = fetch_en;
                if (fetch_en) exp_d = model_mem[fetch_addr];
                tick();
                checks++;
                if (fetch_valid !== exp_v || fetch_data !== exp_d) begin
                    errors++;
                    $display("FAIL rand_fetch[%0d.%0d]: got fv=%0b data=%0h required %0b %0h",
                             it, k, fetch_valid, fetch_data, exp_v, exp_d);
                end
            end
            fetch_en = 1'b0;
            tick();
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 11; i++) words[i] = prog[i];
        run_load(11, 1, 1'b0);
        checks++;
        if (ld_timeout || ld_ready_cyc != 31 || load_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_load: timeout=%0b ready_cyc=%0d done=%0b required 0 31 1", ld_timeout, ld_ready_cyc, load_done);
        end
        checks++;
        if (checksum !== 8'h86) begin
            errors++;
            $display("FAIL bp_checksum: got %0h required 86", checksum);
        end
        fetch_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 8'(a);
            tick();
            checks++;
            if (fetch_valid !== 1'b1 || fetch_data !== model_mem[a]) begin
                errors++;
                $display("FAIL bp_mem[%0d]: got fv=%0b data=%0h required 1 %0h", a, fetch_valid, fetch_data, model_mem[a]);
            end
        end
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        int accepted;
        int cyc;
        logic [DW-1:0] prior3;
        prior3   = model_mem[3];
        accepted = 0;
        cyc      = 0;
        load_start = 1'b1;
        load_len   = 9'd11;
        tick();
        load_start = 1'b0;
        while (accepted < 3 && cyc < 100) begin
            load_valid = 1'b1;
            load_data  = prog[accepted];
            if (load_ready) begin
                model_mem[accepted] = prog[accepted];
                accepted++;
            end
            tick();
            cyc++;
        end
        load_valid = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b0 || checksum !== 8'h00 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL rml_state: busy=%0b rdy=%0b cks=%0h done=%0b required 0 0 00 0",
                     busy, load_ready, checksum, load_done);
        end
        tick();
        checks++;
        if (load_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rml_no_done: done=%0b busy=%0b required 0 0", load_done, busy);
        end
        fetch_en = 1'b1;
        for (int a = 0; a < 4; a++) begin
            logic [DW-1:0] want;
            want = (a < 3) ? prog[a] : prior3;
            fetch_addr = 8'(a);
            tick();
            checks++;
            if (fetch_valid !== 1'b1 || fetch_data !== want) begin
                errors++;
                $display("FAIL rml_fetch[%0d]: got fv=%0b data=%0h required 1 %0h", a, fetch_valid, fetch_data, want);
            end
        end
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_fetch_blocked();
        for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
        words[0] = ~model_mem[0];
        run_load(16, 0, 1'b1);
        checks++;
        if (ld_timeout || ld_fv_seen != 0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL blocked_fv: timeout=%0b fv_cycles=%0d fv_at_done=%0b required 0 0 0",
                     ld_timeout, ld_fv_seen, fetch_valid);
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL blocked_done: got %0b required 1", load_done);
        end
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || fetch_data !== words[0]) begin
            errors++;
            $display("FAIL blocked_first_fetch: got fv=%0b data=%0h required 1 %0h", fetch_valid, fetch_data, words[0]);
        end
        fetch_en = 1'b0;
        tick();
    endtask

    initial begin
        prog[0] = 8'h05; prog[1] = 8'h81; prog[2]  = 8'h0A; prog[3] = 8'h82;
        prog[4] = 8'h44; prog[5] = 8'h99; prog[6]  = 8'h0F; prog[7] = 8'h82;
        prog[8] = 8'h45; prog[9] = 8'h00; prog[10] = 8'hC1;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        model_cks = '0;

        test_reset();
        test_load_sequence();
        test_fetch_after_load();
        test_reject();
        test_out_of_range();
        test_random(4);
        test_backpressure();
        test_random(2);
        test_reset_mid_load();
        test_fetch_blocked();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_rom_loader.md
Name: prog_rom_loader

Overview:
Parametrised, writable successor to the fixed program ROM that feeds the 8-bit CPU's instruction fetch. It holds DEPTH words of program memory and serves registered fetches with 1-cycle latency. A handshaked loader port lets a host (UART/debug bridge) stream a new program in without resynthesis, and reports a running checksum. The block sits between the host loader and the CPU fetch stage. Fetch is stalled (fetch_valid low) while a load is in progress.

Parameters:
DATA_W, 8, instruction word width in bits.
ADDR_W, 8, fetch/load address width in bits.
DEPTH, 256, number of implemented words; legal range 1..2**ADDR_W.

Ports:
clk  in  1  single system clock; all logic on its rising edge.
rst_n  in  1  synchronous, active-low reset.
fetch_en  in  1  fetch request for the current cycle.
fetch_addr  in  ADDR_W  fetch word address.
fetch_data  out  DATA_W  registered fetch result.
fetch_valid  out  1  fetch_data holds the result of the previous cycle's fetch.
load_start  in  1  begin a load of load_len words at address 0.
load_len  in  ADDR_W+1  number of words to load; sampled only with load_start.
load_data  in  DATA_W  loader word.
load_valid  in  1  load_data is valid.
load_ready  out  1  block accepts load_data this cycle.
load_done  out  1  one-cycle pulse after the final word is written.
load_err  out  1  one-cycle pulse when load_start is rejected.
busy  out  1  high while in LOAD.
checksum  out  DATA_W  sum of all words accepted in the current/last load, mod 2**DATA_W.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n low at a clk edge): state=RUN.
- Reset values: fetch_data=0, fetch_valid=0, load_ready=0, load_done=0, load_err=0, busy=0, checksum=0, write pointer=0.
- Memory contents are NOT cleared by reset. They are zero at configuration/simulation start.
- States: RUN, LOAD.
- RUN:
  - fetch_en=1 -> next cycle fetch_valid=1. fetch_data = mem[fetch_addr] if fetch_addr<DEPTH, else 0.
  - fetch_en=0 -> next cycle fetch_valid=0; fetch_data holds its previous value.
- RUN + load_start:
  - If load_len==0 or load_len>DEPTH: load_err pulses for the next cycle, state stays RUN, checksum is unchanged.
  - Otherwise: latch load_len, wr_ptr=0, checksum=0, go to LOAD.
  - A fetch_en in the same cycle as an accepted load_start is dropped: fetch_valid=0 next cycle.
- LOAD:
  - load_ready=1 and busy=1 (both registered, asserted the cycle after load_start).
  - fetch_en is ignored and fetch_valid=0.
  - load_start is ignored: no error, no restart.
- Transfer: a word transfers when load_valid and load_ready are both high. On transfer:
  - mem[wr_ptr] <= load_data
  - checksum <= checksum + load_data, truncated to DATA_W
  - wr_ptr increments
- load_valid low stalls the load indefinitely, with no timeout.
- Last word (wr_ptr == load_len-1 on transfer):
  - Next cycle: state=RUN, load_ready=0, busy=0, load_done=1 for exactly one cycle.
  - The write is complete before RUN. The first fetch in RUN returns new data.
- Reset mid-load:
  - Aborts immediately to RUN and clears checksum.
  - Words already written stay in memory; the rest of memory keeps its previous contents.
  - No load_done pulse.
- checksum is stable between loads and readable at any time.

Test Plan:
- Load sequence (DEPTH=256):
  - Stimulus: load_start with load_len=11, then words 05 81 0A 82 44 99 0F 82 45 00 C1 with load_valid held high.
  - Required: load_ready high for 11 cycles, load_done one pulse, checksum=0x86, busy low after the pulse.
- Fetch after load:
  - Stimulus: fetch_en with addr 0x04, then 0x0A, then 0x0B in consecutive cycles.
  - Required: fetch_data 0x44, 0xC1, 0x00, each one cycle after its address; fetch_valid high for 3 cycles; fetch_en low -> fetch_valid 0 and data held at 0x00.
- Backpressure:
  - Stimulus: the same 11-word load with load_valid toggling 1,0,0,1,...
  - Required: identical memory contents and checksum=0x86; writes only on valid&ready cycles.
- Rejection and out-of-range:
  - Stimulus: load_len=0, then load_len=129 with DEPTH=128.
  - Required: one load_err pulse each, state stays RUN, checksum unchanged.
  - Stimulus: fetch at addr 200 with DEPTH=128.
  - Required: fetch_data=0x00 with fetch_valid=1.
- Reset mid-load:
  - Stimulus: start an 11-word load, accept 3 words, pull rst_n low for 1 cycle.
  - Required: busy=0, load_ready=0, checksum=0, no load_done.
  - Then fetch addr 0,1,2,3. Required: 05, 81, 0A, and the prior contents of addr 3.
- Fetch blocked during load:
  - Stimulus: fetch_en held high throughout a load.
  - Required: fetch_valid=0 from the cycle after load_start until load_done. The first post-load fetch returns the newly written word.
